// File: rtl/pll_reset_sequencer.sv
// PLL reset sequencer: synchronises the PLL lock flag, holds downstream logic in reset until
// lock has been stable long enough, generates the CPU clock enable and counts lock losses.
module pll_reset_sequencer #(
  parameter int SYNC_STAGES  = 2,
  parameter int LOCK_CYCLES  = 1024,
  parameter int RESET_CYCLES = 16,
  parameter int CE_DIV       = 8,
  parameter int CNT_W        = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       locked,
  output logic       sys_reset,
  output logic       ready,
  output logic       ce_cpu,
  output logic [1:0] state,
  output logic [7:0] lock_loss_count
);

  // state      | meaning
  // WAIT_LOCK  | waiting for synchronised lock
  // STABILIZE  | lock must stay high for LOCK_CYCLES
  // HOLD_RESET | reset still asserted, clock enable running
  // RUN        | reset released
  typedef enum logic [1:0] {
    WAIT_LOCK  = 2'd0,
    STABILIZE  = 2'd1,
    HOLD_RESET = 2'd2,
    RUN        = 2'd3
  } state_t;

  localparam int CE_W = (CE_DIV > 1) ? $clog2(CE_DIV) : 1;
  localparam logic [CNT_W-1:0] LOCK_LAST  = CNT_W'(LOCK_CYCLES - 1);
  localparam logic [CNT_W-1:0] RESET_LAST = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CE_W-1:0]  CE_LAST    = CE_W'(CE_DIV - 1);

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [CE_W-1:0]        ce_cnt_q, ce_cnt_d;
  logic [7:0]             loss_q, loss_d;
  logic                   locked_s;
  logic                   lost;
  logic                   ce_active;

  assign locked_s  = sync_q[SYNC_STAGES-1];
  assign ce_active = (state_q == HOLD_RESET) || (state_q == RUN);

  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], locked};
    state_d  = state_q;
    cnt_d    = cnt_q;
    loss_d   = loss_q;
    lost     = 1'b0;
    ce_cnt_d = '0;

    case (state_q)
      WAIT_LOCK: begin
        if (locked_s) begin
          state_d = STABILIZE;
          cnt_d   = '0;
        end
      end
      STABILIZE: begin
        if (!locked_s) begin
          state_d = WAIT_LOCK;
        end else if (cnt_q == LOCK_LAST) begin
          state_d = HOLD_RESET;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HOLD_RESET: begin
        if (!locked_s) begin
          state_d = WAIT_LOCK;
          lost    = 1'b1;
        end else if (cnt_q == RESET_LAST) begin
          state_d = RUN;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RUN: begin
        if (!locked_s) begin
          state_d = WAIT_LOCK;
          lost    = 1'b1;
        end
      end
      default: state_d = WAIT_LOCK;
    endcase

    if (lost && (loss_q != 8'hFF)) begin
      loss_d = loss_q + 8'd1;
    end

    // Entry into HOLD_RESET comes from STABILIZE, so the divider starts from zero there.
    if (ce_active && (state_d != WAIT_LOCK)) begin
      ce_cnt_d = (ce_cnt_q == CE_LAST) ? '0 : ce_cnt_q + CE_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= WAIT_LOCK;
      sync_q   <= '0;
      cnt_q    <= '0;
      ce_cnt_q <= '0;
      loss_q   <= '0;
    end else begin
      state_q  <= state_d;
      sync_q   <= sync_d;
      cnt_q    <= cnt_d;
      ce_cnt_q <= ce_cnt_d;
      loss_q   <= loss_d;
    end
  end

  assign sys_reset       = (state_q != RUN);
  assign ready           = (state_q == RUN);
  assign ce_cpu          = ce_active && (ce_cnt_q == CE_LAST);
  assign state           = state_q;
  assign lock_loss_count = loss_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Bench for pll_reset_sequencer: expected release/drop/first-enable edges are queued when
// stimulus is applied and compared when the DUT output changes.
module tb_pll_reset_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       locked = 1'b0;
  logic       sys_reset;
  logic       ready;
  logic       ce_cpu;
  logic [1:0] state;
  logic [7:0] lock_loss_count;

  int n_chk  = 0;
  int n_fail = 0;
  int edge_cnt = 0;
  int rel_q[$];
  int drop_q[$];
  int ce_q[$];
  bit mon_en = 1'b0;
  bit prev_sr = 1'b1;
  bit ce_pending = 1'b1;
  int last_ce = 0;
  int exp_loss = 0;

  pll_reset_sequencer #(
    .SYNC_STAGES (2),
    .LOCK_CYCLES (8),
    .RESET_CYCLES(4),
    .CE_DIV      (4),
    .CNT_W       (16)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .locked         (locked),
    .sys_reset      (sys_reset),
    .ready          (ready),
    .ce_cpu         (ce_cpu),
    .state          (state),
    .lock_loss_count(lock_loss_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt++;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", tag, obs, exp, edge_cnt);
    end
  endtask

  // Output monitor / scoreboard consumer
  always @(negedge clk) begin
    if (mon_en) begin
      if (prev_sr && !sys_reset) begin
        if (rel_q.size() == 0) chk("unexpected_release", edge_cnt, -1);
        else chk("release_edge", edge_cnt, rel_q.pop_front());
        chk("ready_at_release", int'(ready), 1);
      end
      if (!prev_sr && sys_reset) begin
        if (drop_q.size() == 0) chk("unexpected_drop", edge_cnt, -1);
        else chk("drop_edge", edge_cnt, drop_q.pop_front());
        chk("ready_at_drop", int'(ready), 0);
      end
      if (state < 2'd2) begin
        chk("ce_idle", int'(ce_cpu), 0);
        ce_pending = 1'b1;
      end else if (ce_cpu) begin
        if (ce_pending) begin
          if (ce_q.size() == 0) chk("unexpected_ce", edge_cnt, -1);
          else chk("first_ce_edge", edge_cnt, ce_q.pop_front());
          ce_pending = 1'b0;
        end else begin
          chk("ce_spacing", edge_cnt - last_ce, 4);
        end
        last_ce = edge_cnt;
      end
      prev_sr = sys_reset;
    end
  end

  task automatic wait_state(input int s, input int budget, input string tag);
    int n = 0;
    while (int'(state) != s && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (int'(state) != s) chk(tag, int'(state), s);
  endtask

  // First sampling edge is edge_cnt+1; release 14 edges later, first enable one edge earlier.
  task automatic lock_up(input bit push);
    @(negedge clk);
    locked = 1'b1;
    if (push) begin
      rel_q.push_back(edge_cnt + 15);
      ce_q.push_back(edge_cnt + 14);
    end
  endtask

  task automatic lose_lock();
    @(negedge clk);
    locked = 1'b0;
    drop_q.push_back(edge_cnt + 3);
    if (exp_loss < 255) exp_loss++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, edge %0d", edge_cnt);
    $fatal(1, "watchdog");
  end

  initial begin
    int seq[$];

    reset  = 1'b1;
    locked = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_sys_reset", int'(sys_reset), 1);
    chk("rst_ready", int'(ready), 0);
    chk("rst_ce", int'(ce_cpu), 0);
    chk("rst_state", int'(state), 0);
    chk("rst_loss", int'(lock_loss_count), 0);
    prev_sr = sys_reset;
    mon_en  = 1'b1;

    // Basic release and state sequence
    reset = 1'b0;
    lock_up(1'b1);
    seq.push_back(int'(state));
    for (int n = 0; n < 40 && !ready; n++) begin
      @(negedge clk);
      if (int'(state) != seq[$]) seq.push_back(int'(state));
    end
    chk("seq_len", seq.size(), 4);
    if (seq.size() == 4) begin
      for (int i = 0; i < 4; i++) chk("seq_state", seq[i], i);
    end

    // Clock enable keeps running in RUN
    repeat (12) @(negedge clk);
    chk("run_ready", int'(ready), 1);
    chk("run_sys_reset", int'(sys_reset), 0);

    // Lock loss in RUN, then re-lock
    lose_lock();
    wait_state(0, 10, "loss_to_wait");
    chk("loss_count_1", int'(lock_loss_count), 1);
    chk("loss_sys_reset", int'(sys_reset), 1);
    chk("loss_ce", int'(ce_cpu), 0);
    lock_up(1'b1);
    wait_state(3, 40, "relock_run");

    // Short drop during STABILIZE restarts the count
    lose_lock();
    wait_state(0, 10, "loss2_to_wait");
    lock_up(1'b0);
    wait_state(1, 10, "stab_entry");
    repeat (4) @(negedge clk);
    locked = 1'b0;
    @(negedge clk);
    lock_up(1'b1);
    wait_state(0, 5, "stab_drop_wait");
    chk("stab_drop_loss", int'(lock_loss_count), exp_loss);
    wait_state(3, 40, "stab_relock_run");

    // Many losses: count saturates at 255
    for (int i = 0; i < 258; i++) begin
      lose_lock();
      wait_state(0, 10, "sat_to_wait");
      chk("sat_loss_count", int'(lock_loss_count), exp_loss);
      lock_up(1'b1);
      wait_state(3, 40, "sat_relock_run");
    end
    chk("sat_final", int'(lock_loss_count), 255);

    // Reset on the same edge that locked_s falls: reset wins, no increment
    @(negedge clk);
    locked = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    drop_q.push_back(edge_cnt + 1);
    exp_loss = 0;
    @(negedge clk);
    chk("prio_loss", int'(lock_loss_count), 0);
    chk("prio_state", int'(state), 0);

    // Reset in the middle of HOLD_RESET with lock held
    reset  = 1'b0;
    locked = 1'b1;
    wait_state(2, 40, "hold_entry");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("hold_rst_state", int'(state), 0);
    chk("hold_rst_sys_reset", int'(sys_reset), 1);
    chk("hold_rst_loss", int'(lock_loss_count), 0);
    reset = 1'b0;
    rel_q.push_back(edge_cnt + 15);
    ce_q.push_back(edge_cnt + 14);
    wait_state(3, 40, "hold_rst_run");

    repeat (6) @(negedge clk);
    chk("rel_q_empty", rel_q.size(), 0);
    chk("drop_q_empty", drop_q.size(), 0);
    chk("ce_q_empty", ce_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
